// File: rtl/mad_min_search.sv
// mad_min_search: two-stage minimum-MAD search over a window of MAD rows.
// Stage 1 reduces a row to its lowest-index minimum; stage 2 keeps the earliest strict minimum.
module mad_min_search #(
    parameter int SAD_W = 12,
    parameter int COLS  = 16,
    parameter int ROWS  = 16,
    parameter int MVX_W = 4,
    parameter int MVY_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_valid,
    input  logic                  row_first,
    input  logic                  row_last,
    input  logic [SAD_W*COLS-1:0] row_mad,
    output logic                  res_valid,
    output logic [MVX_W-1:0]      mvx,
    output logic [MVY_W-1:0]      mvy,
    output logic [SAD_W-1:0]      min_mad,
    output logic                  busy
);
    typedef enum logic {IDLE, OPEN} state_t;
    state_t state_q, state_d;
    logic [MVY_W-1:0] cnt_q, cnt_d, idx;
    logic acc, close, take;
    logic s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic [SAD_W-1:0] s1_min_q, s1_min_d, run_min_q, run_min_d, min_q, min_d;
    logic [MVX_W-1:0] s1_col_q, s1_col_d, run_x_q, run_x_d, mvx_q, mvx_d;
    logic [MVY_W-1:0] s1_row_q, s1_row_d, run_y_q, run_y_d, mvy_q, mvy_d;
    logic res_valid_q, res_valid_d;

    always_comb begin
        acc = row_valid && (row_first || state_q == OPEN);
        idx = row_first ? '0 : cnt_q;
        // the row at index ROWS-1 closes the window even without row_last
        close = row_last || idx == MVY_W'(ROWS - 1);
        state_d = acc ? (close ? IDLE : OPEN) : state_q;
        cnt_d = acc ? idx + MVY_W'(1) : cnt_q;
        s1_min_d = row_mad[SAD_W-1:0];
        s1_col_d = '0;
        for (int i = 1; i < COLS; i++) begin
            if (row_mad[i*SAD_W +: SAD_W] < s1_min_d) begin
                s1_min_d = row_mad[i*SAD_W +: SAD_W];
                s1_col_d = MVX_W'(i);
            end
        end
        s1_v_d = acc;
        s1_first_d = row_first;
        s1_last_d = close;
        s1_row_d = idx;
        take = s1_v_q && (s1_first_q || s1_min_q < run_min_q);
        run_min_d = take ? s1_min_q : run_min_q;
        run_x_d = take ? s1_col_q : run_x_q;
        run_y_d = take ? s1_row_q : run_y_q;
        res_valid_d = s1_v_q && s1_last_q;
        min_d = res_valid_d ? run_min_d : min_q;
        mvx_d = res_valid_d ? run_x_d : mvx_q;
        mvy_d = res_valid_d ? run_y_d : mvy_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            s1_v_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q <= 1'b0;
            s1_min_q <= '0;
            s1_col_q <= '0;
            s1_row_q <= '0;
            run_min_q <= '0;
            run_x_q <= '0;
            run_y_q <= '0;
            res_valid_q <= 1'b0;
            min_q <= '0;
            mvx_q <= '0;
            mvy_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            s1_v_q <= s1_v_d;
            s1_first_q <= s1_first_d;
            s1_last_q <= s1_last_d;
            s1_min_q <= s1_min_d;
            s1_col_q <= s1_col_d;
            s1_row_q <= s1_row_d;
            run_min_q <= run_min_d;
            run_x_q <= run_x_d;
            run_y_q <= run_y_d;
            res_valid_q <= res_valid_d;
            min_q <= min_d;
            mvx_q <= mvx_d;
            mvy_q <= mvy_d;
        end
    end

    assign res_valid = res_valid_q;
    assign mvx = mvx_q;
    assign mvy = mvy_q;
    assign min_mad = min_q;
    assign busy = state_q == OPEN;
endmodule

// File: tb/tb_mad_min_search.sv
// tb_mad_min_search: directed windows on a default and a small build of mad_min_search,
// with expected results queued at the closing row and compared when res_valid pulses.
module tb_mad_min_search;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_tests = 0;
    int n_fail = 0;
    int last_a = 0;
    int last_b = 0;

    typedef struct {int x; int y; int mad; int c;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic a_v = 1'b0, a_f = 1'b0, a_l = 1'b0;
    logic [191:0] a_mad = '0;
    logic a_rv, a_busy;
    logic [3:0] a_x, a_y;
    logic [11:0] a_min;

    logic b_v = 1'b0, b_f = 1'b0, b_l = 1'b0;
    logic [127:0] b_mad = '0;
    logic b_rv, b_busy;
    logic [2:0] b_x;
    logic [1:0] b_y;
    logic [15:0] b_min;

    mad_min_search dut_a (
        .clk(clk), .rst_n(rst_n), .row_valid(a_v), .row_first(a_f), .row_last(a_l),
        .row_mad(a_mad), .res_valid(a_rv), .mvx(a_x), .mvy(a_y), .min_mad(a_min), .busy(a_busy)
    );

    mad_min_search #(.SAD_W(16), .COLS(8), .ROWS(4), .MVX_W(3), .MVY_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .row_valid(b_v), .row_first(b_f), .row_last(b_l),
        .row_mad(b_mad), .res_valid(b_rv), .mvx(b_x), .mvy(b_y), .min_mad(b_min), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rv) begin
            check("a_res_expected", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("a_mvx", a_x, ea.x);
                check("a_mvy", a_y, ea.y);
                check("a_min_mad", a_min, ea.mad);
                check("a_res_cycle", cyc, ea.c);
            end
        end
        if (b_rv) begin
            check("b_res_expected", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("b_mvx", b_x, eb.x);
                check("b_mvy", b_y, eb.y);
                check("b_min_mad", b_min, eb.mad);
                check("b_res_cycle", cyc, eb.c);
            end
        end
    end

    function automatic logic [191:0] a_fill(input int bg);
        logic [191:0] d;
        for (int i = 0; i < 16; i++) d[i*12 +: 12] = 12'(bg);
        return d;
    endfunction

    function automatic logic [127:0] b_fill(input int bg);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(bg);
        return d;
    endfunction

    task automatic a_row(input logic f, input logic l, input logic [191:0] d);
        @(negedge clk);
        a_v = 1'b1; a_f = f; a_l = l; a_mad = d;
        last_a = cyc;
    endtask

    task automatic a_idle();
        @(negedge clk);
        a_v = 1'b0; a_f = 1'b0; a_l = 1'b0;
    endtask

    task automatic b_row(input logic f, input logic l, input logic [127:0] d);
        @(negedge clk);
        b_v = 1'b1; b_f = f; b_l = l; b_mad = d;
        last_b = cyc;
    endtask

    task automatic b_idle();
        @(negedge clk);
        b_v = 1'b0; b_f = 1'b0; b_l = 1'b0;
    endtask

    task automatic a_win(input int n, input bit with_last, input int bg,
                         input int x1, input int y1, input int v1,
                         input int x2, input int y2, input int v2);
        logic [191:0] d;
        for (int r = 0; r < n; r++) begin
            d = a_fill(bg);
            if (r == y1) d[x1*12 +: 12] = 12'(v1);
            if (r == y2) d[x2*12 +: 12] = 12'(v2);
            a_row(r == 0, with_last && r == n - 1, d);
        end
    endtask

    task automatic push_a(input int x, input int y, input int m);
        qa.push_back(exp_t'{x: x, y: y, mad: m, c: last_a + 2});
    endtask

    task automatic push_b(input int x, input int y, input int m);
        qb.push_back(exp_t'{x: x, y: y, mad: m, c: last_b + 2});
    endtask

    initial begin
        logic [127:0] bd;
        repeat (3) @(negedge clk);
        check("rst_a_res_valid", a_rv, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_mvx", a_x, 0);
        check("rst_a_mvy", a_y, 0);
        check("rst_a_min", a_min, 0);
        check("rst_b_res_valid", b_rv, 0);
        check("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;

        // single window, minimum at (9,5)
        a_win(16, 1, 'hFFF, 9, 5, 'h010, 9, 5, 'h010);
        push_a(9, 5, 'h010);
        a_idle();
        check("busy_after_close", a_busy, 0);
        repeat (3) a_idle();

        // ties everywhere, then two equal minima
        a_win(16, 1, 100, 0, 0, 100, 0, 0, 100);
        push_a(0, 0, 100);
        a_win(16, 1, 100, 3, 2, 50, 1, 7, 50);
        push_a(3, 2, 50);

        // back-to-back windows; C's larger min must not be polluted by B
        a_win(16, 1, 'hFFF, 4, 1, 7, 4, 1, 7);
        push_a(4, 1, 7);
        a_win(16, 1, 'hFFF, 15, 15, 3, 15, 15, 3);
        push_a(15, 15, 3);
        a_win(16, 1, 'hFFF, 6, 6, 20, 6, 6, 20);
        push_a(6, 6, 20);

        // abort after 6 rows, restarted window wins
        a_win(6, 0, 'hFFF, 0, 2, 1, 0, 2, 1);
        a_win(16, 1, 'hFFF, 2, 4, 9, 2, 4, 9);
        push_a(2, 4, 9);

        // auto-close without row_last, then rows that must be ignored
        a_win(16, 0, 'hFFF, 8, 10, 5, 8, 10, 5);
        push_a(8, 10, 5);
        a_row(0, 0, a_fill(0));
        check("busy_autoclose", a_busy, 0);
        a_row(0, 0, a_fill(0));
        a_row(0, 1, a_fill(0));
        a_idle();
        check("busy_after_ignored", a_busy, 0);
        repeat (3) a_idle();

        // reset mid-window
        a_win(9, 0, 'hFFF, 2, 3, 1, 2, 3, 1);
        a_idle();
        check("busy_mid_window", a_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_res_valid", a_rv, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_mvx", a_x, 0);
        check("midrst_mvy", a_y, 0);
        check("midrst_min", a_min, 0);
        repeat (4) a_idle();
        a_win(16, 1, 'hFFF, 11, 12, 2, 11, 12, 2);
        push_a(11, 12, 2);
        a_idle();

        // small build: 4-row window then a single-row window
        for (int r = 0; r < 4; r++) begin
            bd = b_fill('hFFFF);
            if (r == 3) bd[7*16 +: 16] = 16'h0001;
            b_row(r == 0, r == 3, bd);
        end
        push_b(7, 3, 1);
        bd = b_fill('h0200);
        bd[15:0] = 16'h0100;
        b_row(1, 1, bd);
        push_b(0, 0, 'h100);
        b_idle();
        check("b_busy_single", b_busy, 0);

        repeat (6) @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mad_min_search.md
# mad_min_search

Pipelined minimum-MAD search for block-matching motion estimation. Consumes one row of COLS candidate MAD values per accepted beat, tracks the running minimum over up to ROWS rows, and emits the winning motion vector (column, row) and its MAD once per search window. Sits between the MAD processing-element array and the motion-vector writeback, as the parametrised successor of the fixed 16x16, 12-bit comparator.

## Interface
- SAD_W, 12, width of one MAD value (unsigned)
- COLS, 16, candidates per row (horizontal search positions), >= 2
- ROWS, 16, maximum rows per search window, >= 2
- MVX_W, 4, width of mvx; must satisfy 2**MVX_W >= COLS
- MVY_W, 4, width of mvy; must satisfy 2**MVY_W >= ROWS

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- row_valid  in  1  row_mad carries a valid row this cycle; always accepted (no backpressure)
- row_first  in  1  qualifies row_valid: this row is row 0 of a new window
- row_last  in  1  qualifies row_valid: this row closes the window
- row_mad  in  SAD_W*COLS  packed row; candidate i at bits [i*SAD_W +: SAD_W]
- res_valid  out  1  one-cycle pulse: mvx/mvy/min_mad hold a new result
- mvx  out  MVX_W  column index of the minimum
- mvy  out  MVY_W  row index of the minimum
- min_mad  out  SAD_W  minimum MAD value
- busy  out  1  window open (row_first accepted, result not yet issued)

## Operation
- Row index counter (MVY_W bits) assigned internally: row_first row = 0, each subsequent accepted row +1. No external row index.
- Stage 1 (row reduce): lowest-index strict-less-than reduction of COLS values -> (row_min, row_col, row_idx, first, last) registered.
- Stage 2 (accumulate): if first: run_min/run_x/run_y <= stage-1 values; else replace only if row_min < run_min (strict). Ties keep the earlier candidate: lowest row, then lowest column.
- Window close: when stage 2 processes a row flagged last, result registers load the final winner and res_valid pulses.
- Auto-close: the row with index ROWS-1 is treated as last even if row_last=0; further rows without row_first are ignored (no update, no result) until next row_first.
- row_valid with row_first while busy: current window aborted silently (no res_valid for it), new window starts at row 0.
- row_valid without row_first while idle: ignored.
- row_first and row_last together: single-row window, valid.
- row_first/row_last are ignored when row_valid=0.
- States: IDLE (busy=0) -> OPEN on row_first; OPEN -> IDLE when the closing row is accepted; abort keeps OPEN.

## Timing
- Row accepted at edge N -> stage 1 registered at N -> stage 2 updated at N+1.
- Closing row at edge N -> res_valid=1 and outputs updated at edge N+1 (visible cycle after N+1), res_valid low again after edge N+2 unless another window closes.
- Throughput: one row per cycle, back-to-back windows with no bubble (row_first may immediately follow row_last).
- mvx/mvy/min_mad hold their last result until the next res_valid.
- busy rises at the edge accepting row_first, falls at the edge accepting the closing row.
- Reset (rst_n=0 at an edge): res_valid=0, busy=0, mvx=0, mvy=0, min_mad=0, row counter=0, pipeline valids cleared; in-flight rows discarded; reset mid-window yields no result.

## Test plan
- Single window, 16 rows, all MADs 0xFFF except row 5 col 9 = 0x010 -> one res_valid 2 cycles after last row; mvx=9, mvy=5, min_mad=0x010.
- Ties: every MAD = 100 across 16 rows -> mvx=0, mvy=0, min_mad=100; second tie value 50 at (3,2) and (1,7) -> mvx=3, mvy=2.
- Back-to-back windows: window A min 7 at (4,1), window B starts next cycle with min 3 at (15,15) -> two res_valid pulses 16 cycles apart with those results; B's min not polluted by A.
- Abort and auto-close: row_first at row 6 of a window -> no result for aborted window; a 16-row window without row_last -> result after row 15, extra rows ignored, busy=0.
- Reset mid-window after row 8 with min 1 at (2,3) -> all outputs 0, no res_valid; following clean window gives correct result.
- Parametrised build COLS=8, ROWS=4, SAD_W=16: min 0x0001 at (7,3), row_first+row_last single-row window min at col 0 -> mvx=7,mvy=3 then mvx=0,mvy=0.
